// File: rtl/pipelined_add_sub_nbit.sv
// Pipelined N-bit adder/subtractor resolving one W-bit chunk per stage.
// Global stall holds every stage while the output waits on the consumer.
module pipelined_add_sub_nbit #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Z,
  output logic         Neg,
  output logic         V
);

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub_nbit: N must split evenly into 1..N stages");
  end

  localparam int W = N / STAGES;

  logic [N-1:0] be;
  logic         c0;
  logic         stall;

  logic [N-1:0] r_a [STAGES];
  logic [N-1:0] r_b [STAGES];
  logic [N-1:0] r_s [STAGES];
  logic         r_c [STAGES];
  logic         r_v [STAGES];

  logic [N-1:0] src_a [STAGES];
  logic [N-1:0] src_b [STAGES];
  logic [N-1:0] src_s [STAGES];
  logic         src_c [STAGES];

  logic [W:0]   part  [STAGES];
  logic [N-1:0] nx_s  [STAGES];
  logic         nx_c  [STAGES];

  logic z_r, neg_r, v_r;
  logic z_n, neg_n, v_n;

  assign be    = op ? ~B : B;
  assign c0    = op | Cin;
  assign stall = r_v[STAGES-1] & ~out_ready;

  always_comb begin
    src_a[0] = A;
    src_b[0] = be;
    src_s[0] = '0;
    src_c[0] = c0;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = r_a[k-1];
      src_b[k] = r_b[k-1];
      src_s[k] = r_s[k-1];
      src_c[k] = r_c[k-1];
    end
  end

  // Each stage fills in its own chunk; lower chunks ride along untouched.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, src_a[k][k*W +: W]}
              + {1'b0, src_b[k][k*W +: W]}
              + {{W{1'b0}}, src_c[k]};
      nx_s[k] = src_s[k];
      nx_s[k][k*W +: W] = part[k][W-1:0];
      nx_c[k] = part[k][W];
    end
  end

  always_comb begin
    z_n   = (nx_s[STAGES-1] == '0);
    neg_n = nx_s[STAGES-1][N-1];
    v_n   = (src_a[STAGES-1][N-1] == src_b[STAGES-1][N-1])
         && (nx_s[STAGES-1][N-1] != src_a[STAGES-1][N-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      z_r   <= 1'b0;
      neg_r <= 1'b0;
      v_r   <= 1'b0;
    end else if (!stall) begin
      r_v[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        r_v[k] <= r_v[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= src_a[k];
        r_b[k] <= src_b[k];
        r_s[k] <= nx_s[k];
        r_c[k] <= nx_c[k];
      end
      z_r   <= z_n;
      neg_r <= neg_n;
      v_r   <= v_n;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = r_v[STAGES-1];
  assign S         = r_s[STAGES-1];
  assign Cout      = r_c[STAGES-1];
  assign Z         = z_r;
  assign Neg       = neg_r;
  assign V         = v_r;

endmodule
